// File: rtl/mem_access_ctrl_if.sv
// Bus between the datapath/mem16 side and the memory access sequencer.
// The master side drives requests and memory read data; the slave side is the sequencer.
interface mem_access_ctrl_if;
  localparam int unsigned DW = 16;

  logic          req;
  logic          rw;
  logic          word;
  logic [DW-1:0] mar;
  logic [DW-1:0] mdr_in;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write_n;
  logic          mem_ir14;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          busy;
  logic          unaligned;

  modport master (
    output req, rw, word, mar, mdr_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_write_n, mem_ir14, rdata, ready, busy, unaligned
  );

  modport slave (
    input  req, rw, word, mar, mdr_in, mem_rdata,
    output mem_addr, mem_wdata, mem_write_n, mem_ir14, rdata, ready, busy, unaligned
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: latches one request, holds it on the mem16 pins for
// WAIT_CYCLES cycles, returns read data with a one-cycle ready pulse.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus
);
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, FAULT, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [DW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              ir14_q, ir14_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              write_n_q, write_n_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              unaligned_q, unaligned_d;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ir14_q      <= 1'b1;
      rdata_q     <= '0;
      write_n_q   <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      unaligned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ir14_q      <= ir14_d;
      rdata_q     <= rdata_d;
      write_n_q   <= write_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      unaligned_q <= unaligned_d;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir14_d  = ir14_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.mar;
          wdata_d = bus.mdr_in;
          ir14_d  = bus.word;
          rw_d    = bus.rw;
          if (bus.word && bus.mar[0]) begin
            state_d = FAULT;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      FAULT: state_d = IDLE;
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!rw_q) rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobe is registered, so it is decoded from the state being entered
    write_n_d   = !((state_d == ACCESS) && (cnt_d == '0) && rw_d);
    ready_d     = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    unaligned_d = (state_d == FAULT);
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_write_n = write_n_q;
  assign bus.mem_ir14    = ir14_q;
  assign bus.rdata       = rdata_q;
  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.unaligned   = unaligned_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=4.
module tb_mem_access_ctrl;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset_vals(input string tag);
    check({tag, "_addr"},   bus.mem_addr, 16'h0000);
    check({tag, "_wdata"},  bus.mem_wdata, 16'h0000);
    check({tag, "_wr_n"},   16'(bus.mem_write_n), 16'd1);
    check({tag, "_ir14"},   16'(bus.mem_ir14), 16'd1);
    check({tag, "_rdata"},  bus.rdata, 16'h0000);
    check({tag, "_ready"},  16'(bus.ready), 16'd0);
    check({tag, "_busy"},   16'(bus.busy), 16'd0);
    check({tag, "_unal"},   16'(bus.unaligned), 16'd0);
  endtask

  // One aligned access from an IDLE cycle; c counts cycles after the accept edge
  task automatic do_access(input string tag, input logic rw, input logic word,
                           input logic [15:0] mar, input logic [15:0] wd,
                           input logic [15:0] mrd, input logic [15:0] exp_rdata);
    bus.req = 1'b1; bus.rw = rw; bus.word = word;
    bus.mar = mar; bus.mdr_in = wd; bus.mem_rdata = mrd;
    tick();
    bus.req = 1'b0;
    for (int c = 0; c <= int'(W) + 1; c++) begin
      if (c == 0) begin
        check({tag, "_addr"},  bus.mem_addr, mar);
        check({tag, "_wdata"}, bus.mem_wdata, wd);
        check({tag, "_ir14"},  16'(bus.mem_ir14), 16'(word));
      end
      check({tag, "_ready"}, 16'(bus.ready), 16'(c == int'(W)));
      check({tag, "_wr_n"},  16'(bus.mem_write_n), 16'(!(rw && c == int'(W) - 1)));
      check({tag, "_busy"},  16'(bus.busy), 16'(c <= int'(W)));
      check({tag, "_unal"},  16'(bus.unaligned), 16'd0);
      if (c == int'(W)) check({tag, "_rdata"}, bus.rdata, exp_rdata);
      if (c <= int'(W)) tick();
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.rw = 1'b0; bus.word = 1'b1;
    bus.mar = '0; bus.mdr_in = '0; bus.mem_rdata = '0;

    tick(); tick();
    check_idle_reset_vals("rst");
    reset = 1'b0;
    tick();

    do_access("wrd_rd", 1'b0, 1'b1, 16'h0010, 16'h5555, 16'hBEEF, 16'hBEEF);
    do_access("wrd_wr", 1'b1, 1'b1, 16'h0020, 16'h1234, 16'hAAAA, 16'hBEEF);
    do_access("byt_rd", 1'b0, 1'b0, 16'h0021, 16'h0000, 16'hFF80, 16'hFF80);

    // Unaligned word request: one-cycle fault, nothing reaches memory
    bus.req = 1'b1; bus.rw = 1'b0; bus.word = 1'b1; bus.mar = 16'h0033; bus.mem_rdata = 16'h1111;
    tick();
    bus.req = 1'b0;
    check("flt_unal0", 16'(bus.unaligned), 16'd1);
    check("flt_busy0", 16'(bus.busy), 16'd1);
    check("flt_addr",  bus.mem_addr, 16'h0033);
    for (int c = 0; c < 4; c++) begin
      check("flt_ready", 16'(bus.ready), 16'd0);
      check("flt_wr_n",  16'(bus.mem_write_n), 16'd1);
      check("flt_rdata", bus.rdata, 16'hFF80);
      tick();
      check("flt_unal",  16'(bus.unaligned), 16'd0);
      check("flt_busy",  16'(bus.busy), 16'd0);
    end

    // req held high: second write accepted in the IDLE cycle after DONE
    bus.req = 1'b1; bus.rw = 1'b1; bus.word = 1'b1; bus.mar = 16'h0040; bus.mdr_in = 16'hCAFE;
    tick();
    for (int c = 0; c <= 2 * int'(W) + 4; c++) begin
      check("b2b_ready", 16'(bus.ready), 16'(c == int'(W) || c == 2 * int'(W) + 2));
      check("b2b_wr_n",  16'(bus.mem_write_n),
            16'(!(c == int'(W) - 1 || c == 2 * int'(W) + 1)));
      check("b2b_busy",  16'(bus.busy), 16'(c <= 2 * int'(W) + 2 && c != int'(W) + 1));
      check("b2b_unal",  16'(bus.unaligned), 16'd0);
      if (c == 2 * int'(W) + 2) bus.req = 1'b0;
      tick();
    end

    // Reset during the 2nd ACCESS cycle of a write aborts without a ready pulse
    bus.req = 1'b1; bus.rw = 1'b1; bus.mar = 16'h0050; bus.mdr_in = 16'h7777;
    tick();
    bus.req = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    check_idle_reset_vals("ab1");
    #2 reset = 1'b0;
    for (int c = 0; c < int'(W) + 2; c++) begin
      tick();
      check("ab1_ready", 16'(bus.ready), 16'd0);
      check("ab1_busy",  16'(bus.busy), 16'd0);
    end

    // Reset while the strobe is active drops it without waiting for an edge
    bus.req = 1'b1; bus.rw = 1'b1; bus.mar = 16'h0060; bus.mdr_in = 16'h9999;
    tick();
    bus.req = 1'b0;
    for (int c = 0; c < int'(W) - 1; c++) tick();
    check("ab2_strobe", 16'(bus.mem_write_n), 16'd0);
    reset = 1'b1;
    #2;
    check("ab2_wr_n", 16'(bus.mem_write_n), 16'd1);
    #2 reset = 1'b0;
    tick();
    check("ab2_ready", 16'(bus.ready), 16'd0);

    do_access("post_rd", 1'b0, 1'b1, 16'h0070, 16'h0000, 16'h4321, 16'h4321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
